pm_select_ctrl: RTL
===================

# pm_select_ctrl

Sequential path-metric selection controller for the Viterbi decoder. Accepts one set of four unsigned path metrics per symbol over a valid/ready handshake and finds the minimum with a single shared comparator over three compare cycles. It returns the winning state index on `d1`/`d0`, the minimum metric, and the metric set, normalized against the minimum when enabled. It sits between the add-compare-select stage and the traceback unit.

## Interface
- `W`, default 4: width of each path metric, unsigned.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: metric set on `pm0`..`pm3` is valid.
- `in_ready` output 1: block can accept a metric set.
- `pm0`, `pm1`, `pm2`, `pm3` input W each: path metrics of states 0..3.
- `out_valid` output 1: result outputs are valid.
- `out_ready` input 1: downstream accepts the result.
- `d1`, `d0` output 1 each: winning state index, with `d1` as MSB.
- `min_pm` output W: minimum metric.
- `out_pm` output 4*W: metric set, state 0 in bits [W-1:0].
- `busy` output 1: high when the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
    - On `in_valid`, capture `pm0`..`pm3` into registers and load best=pm0, best_idx=0, cnt=1.
    - Go to CMP.
  - CMP: each cycle, compare captured pm[cnt] against best.
    - If pm[cnt] < best (strict), set best=pm[cnt] and best_idx=cnt.
    - Increment cnt.
    - When cnt=3 is processed, go to DONE.
  - DONE: `out_valid`=1 and all outputs are held stable.
    - When `out_ready`=1, go to IDLE.
- Tie-break: with strict less-than, the lowest index wins among equal minima.
- Arithmetic is unsigned W-bit.
  - Compare only; no addition happens inside the block.
  - Normalization subtraction (see Configuration) cannot underflow, because min ≤ every metric.
- `in_valid` is ignored outside IDLE. Input pins may change freely after capture.
- `d1`, `d0`, `min_pm` and `out_pm` update only on the transition into DONE. They keep their last values in IDLE and CMP.
- Reset asserted in any state, including mid-CMP or DONE with `out_valid` pending:
  - Immediately return to IDLE and discard the captured set.
  - No partial result is ever presented.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `d1`=`d0`=0, `min_pm`=0, `out_pm`=0. All internal registers are 0.
- Accept edge is E0 (`in_valid`&&`in_ready` at a rising edge).
- Compare edges are E1, E2, E3; the state enters DONE at E3.
- `out_valid` rises after E3, i.e. 3 cycles after the accept edge.
- Output handshake completes at the edge where `out_valid`&&`out_ready`. `in_ready` rises the following cycle.
- With `out_ready` tied high, each set takes 5 cycles. The next accept is possible 5 edges after the previous one.
- `in_ready` is purely a function of state: high in IDLE only, no combinational path from `out_ready`.
- `out_valid` stays high and outputs stay constant for any number of cycles while `out_ready`=0.

## Configuration
- Macro: `PM_SELECT_NORM_EN`.
- Defined: on entry to DONE, `out_pm` holds each captured metric minus `min_pm`.
  - The winning state's metric is therefore always 0.
  - This prevents metric growth in the downstream ACS loop.
- Undefined: `out_pm` holds the captured metrics unchanged.
  - No subtractors are synthesized.
  - FSM, latency and other outputs are identical in both builds.

## Test plan
- Sets (1,3,5,15), (15,1,3,5), (5,15,1,3), (3,5,15,1) each sent with `out_ready`=1:
  - indices `d1``d0` = 00, 01, 10, 11 respectively; `min_pm`=1 for every set.
  - with `PM_SELECT_NORM_EN`, `out_pm` for the first set = (0,2,4,14).
- Latency: accept at edge k gives `out_valid` high after edge k+3. `in_ready` is low from after k through the handshake edge.
- Ties:
  - (7,7,2,2) gives index 10, `min_pm`=2.
  - (9,9,9,9) gives index 00, `min_pm`=9, normalized `out_pm`=(0,0,0,0).
- Backpressure:
  - Hold `out_ready`=0 for 6 cycles with `in_valid` held high and different pins applied. Outputs stay constant and no new capture occurs.
  - Then raise `out_ready`; the next set is accepted one cycle after the handshake.
- Reset mid-operation: assert `rst_n`=0 during the second CMP cycle. `out_valid`=0, `in_ready`=1 and all outputs return to 0 immediately. After release, the set (4,2,8,6) yields index 01, `min_pm`=2.
- Build without `PM_SELECT_NORM_EN`: (1,3,5,15) gives `out_pm`=(1,3,5,15), index 00 and `min_pm`=1, with identical cycle timing.

Source files
------------

// File: rtl/pm_select_ctrl.sv
// pm_select_ctrl: sequential minimum finder over four unsigned path metrics.
// One shared comparator walks metrics 1..3 against the running best, which
// starts at metric 0, and takes three compare cycles.
// Optional feature macro: PM_SELECT_NORM_EN. When it is defined, out_pm is
// normalized against the minimum. When it is undefined, out_pm carries the
// raw captured metrics and no subtractors are built.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready.
// The producer holds its data stable while valid is high and not yet
// accepted. in_ready is high only in IDLE and depends on state alone.
// out_valid is high only in DONE. While out_ready is low, every result
// output holds its value.
module pm_select_ctrl #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   pm0,
    input  logic [W-1:0]   pm1,
    input  logic [W-1:0]   pm2,
    input  logic [W-1:0]   pm3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           d1,
    output logic           d0,
    output logic [W-1:0]   min_pm,
    output logic [4*W-1:0] out_pm,
    output logic           busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   pm_q [4];
    logic [W-1:0]   best;
    logic [1:0]     best_idx;
    logic [1:0]     cnt;
    logic [1:0]     res_idx;
    logic [W-1:0]   res_min;
    logic [4*W-1:0] res_pm;

    logic [W-1:0]   cand;
    logic           take;
    logic [W-1:0]   nxt_best;
    logic [1:0]     nxt_idx;

    // Shared comparator. A strict less-than keeps the lowest index among equal minima.
    always_comb begin
        cand     = pm_q[cnt];
        take     = cand < best;
        nxt_best = take ? cand : best;
        nxt_idx  = take ? cnt : best_idx;
    end

    // Capture, compare-walk and result registers. Results load only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            for (int i = 0; i < 4; i++) pm_q[i] <= '0;
            best     <= '0;
            best_idx <= '0;
            cnt      <= '0;
            res_idx  <= '0;
            res_min  <= '0;
            res_pm   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        pm_q[0]  <= pm0;
                        pm_q[1]  <= pm1;
                        pm_q[2]  <= pm2;
                        pm_q[3]  <= pm3;
                        best     <= pm0;
                        best_idx <= 2'd0;
                        cnt      <= 2'd1;
                        state    <= S_CMP;
                    end
                end
                S_CMP: begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    cnt      <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state   <= S_DONE;
                        res_idx <= nxt_idx;
                        res_min <= nxt_best;
`ifdef PM_SELECT_NORM_EN
                        // The minimum is never larger than any metric, so these subtractions cannot wrap.
                        res_pm  <= {pm_q[3] - nxt_best, pm_q[2] - nxt_best,
                                    pm_q[1] - nxt_best, pm_q[0] - nxt_best};
`else
                        res_pm  <= {pm_q[3], pm_q[2], pm_q[1], pm_q[0]};
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status and result outputs are decoded from registered state only.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        d1        = res_idx[1];
        d0        = res_idx[0];
        min_pm    = res_min;
        out_pm    = res_pm;
    end

endmodule
